tdm_serializer_1_4: RTL and testbench
=====================================

Name: tdm_serializer_1_4

Overview:
- Upstream feeder for the 1:4 behavioural demux (demux_1_4).
- Accepts one parallel word per channel for four channels. Shifts each word out bit-serially on `i` while driving `sel` to the matching channel, so the downstream demux routes every bit to its y0..y3 output.
- Time-division multiplexes the four channels in ascending order and skips disabled channels.
- Signals the end of each frame to the producer.

Parameters:
- WIDTH, 8, bits per channel word; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- load_valid  input  1  producer has a frame ready
- load_ready  output  1  block can accept a frame (high only in IDLE)
- ch_data  input  4*WIDTH  channel words; channel c at bits [c*WIDTH +: WIDTH]
- ch_en  input  4  per-channel enable mask; bit c enables channel c
- sel  output  2  channel select to the demux
- i  output  1  serial data bit to the demux
- bit_valid  output  1  sel/i carry a valid bit this cycle
- parity_flag  output  1  current bit is a parity bit (see Optional Feature)
- frame_done  output  1  one-cycle pulse: frame fully transmitted

Behaviour:
- Interface (decided): one clock, clk; reset rst is synchronous and active-high.
- All outputs are registered, except load_ready, which is decoded from the state register.
- Reset values: sel=2'b00, i=0, bit_valid=0, parity_flag=0, frame_done=0, state=IDLE, load_ready=1.
- States: IDLE, SHIFT.
- IDLE:
  - load_ready=1.
  - Handshake completes when load_valid && load_ready at a rising edge N.
  - On handshake, the block latches ch_data and ch_en into internal registers. Inputs are don't-care after the handshake.
- IDLE -> SHIFT when the handshake completes and the latched ch_en != 0.
  - First bit appears at cycle N+1: sel = lowest enabled channel, i = MSB of that word, bit_valid=1.
- Handshake with ch_en == 0: stays in IDLE; frame_done=1 at cycle N+1; no bits are sent.
- SHIFT:
  - One bit per cycle, MSB first, bit_valid=1, sel constant for the whole word.
  - After bit 0 of the current channel, the next cycle carries the MSB of the next higher enabled channel. No gap cycles; disabled channels are skipped with zero cycles spent.
  - Bit counter counts WIDTH-1 down to 0 and reloads on each channel change.
- SHIFT -> IDLE after the last bit of the highest enabled channel, at cycle T.
  - At T+1: frame_done=1, bit_valid=0, i=0, load_ready=1.
  - sel holds its last value until the next frame.
  - A new handshake is accepted at T+1 (back-to-back frames; first bit of the new frame at T+2).
- Frame length in cycles: popcount(ch_en)*WIDTH, plus popcount(ch_en) when PARITY_EN is defined.
- load_valid in SHIFT: ignored; load_ready=0, no latch.
- rst mid-frame: aborts the frame.
  - Next edge applies all reset values; no frame_done for the aborted frame.
  - Latched data is discarded.
- frame_done is never asserted for more than one consecutive cycle unless back-to-back empty frames are loaded.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - After bit 0 of each channel word, one extra cycle is inserted with the same sel, bit_valid=1, parity_flag=1.
  - i = even parity of that word (XOR of all WIDTH bits).
  - The next channel starts the following cycle.
- Undefined:
  - No parity cycle is inserted.
  - parity_flag is tied to 0.
  - Port list is unchanged.

Test Plan:
1. Reset then idle: hold rst=1 for 2 cycles, release -> sel=0, i=0, bit_valid=0, frame_done=0, load_ready=1; stays IDLE with load_valid=0.
2. Single channel: WIDTH=8, ch_en=4'b0100, ch2 word=8'hA5 -> cycles N+1..N+8 have sel=2, i=1,0,1,0,0,1,0,1, bit_valid=1; frame_done=1 at N+9 with load_ready=1.
3. Skip disabled channels: ch_en=4'b1011, words ch0=8'h01, ch1=8'h80, ch3=8'hFF -> 24 consecutive valid bits with sel sequence 0x8, 1x8, 3x8, never 2. ch0 bit stream 00000001; frame_done at N+25.
4. Empty mask and back-to-back: ch_en=4'b0000 -> frame_done at N+1, no bit_valid. Then hold load_valid=1 with ch_en=4'b0001, word 8'h3C -> new handshake at the frame_done cycle; bits begin the next cycle.
5. Reset mid-frame: ch_en=4'b1111, assert rst at the 5th bit of ch1 -> next edge all outputs at reset values, no frame_done; a subsequent frame starts cleanly from the lowest enabled channel.
6. TDM_PARITY_EN defined: ch_en=4'b0011, ch0=8'h07, ch1=8'h03 -> ch0 bits then a parity cycle (sel=0, i=1, parity_flag=1), ch1 bits then a parity cycle (sel=1, i=0, parity_flag=1); frame_done at N+19.

Source files
------------

// File: rtl/tdm_serializer_1_4.sv
// tdm_serializer_1_4: shifts four channel words MSB-first onto sel/i for demux_1_4, skipping disabled channels.
// Define TDM_PARITY_EN to append an even-parity bit after each channel word.
module tdm_serializer_1_4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [4*WIDTH-1:0] ch_data,
  input  logic [3:0]         ch_en,
  output logic [1:0]         sel,
  output logic               i,
  output logic               bit_valid,
  output logic               parity_flag,
  output logic               frame_done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [4*WIDTH-1:0] data_q;
  logic [3:0] en_q, nxt_mask;
  logic [CW-1:0] cnt;
  logic [1:0] nxt_ch, first_ch;
  logic [WIDTH-1:0] cur_word, nxt_word, first_word;
  function automatic logic [1:0] lowest(input logic [3:0] m);
    lowest = 2'd0;
    for (int k = 3; k >= 0; k--) if (m[k]) lowest = 2'(k);
  endfunction
  function automatic logic [WIDTH-1:0] word_of(input logic [4*WIDTH-1:0] d, input logic [1:0] c);
    word_of = d[0 +: WIDTH];
    for (int k = 1; k < 4; k++) if (c == 2'(k)) word_of = d[k*WIDTH +: WIDTH];
  endfunction
  // only channels strictly above the current one are candidates for the next word
  assign nxt_mask   = en_q & (4'b1110 << sel);
  assign nxt_ch     = lowest(nxt_mask);
  assign first_ch   = lowest(ch_en);
  assign cur_word   = word_of(data_q, sel);
  assign nxt_word   = word_of(data_q, nxt_ch);
  assign first_word = word_of(ch_data, first_ch);
  assign load_ready = state == IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= 2'b00;
      i          <= 1'b0;
      bit_valid  <= 1'b0;
      frame_done <= 1'b0;
      data_q     <= '0;
      en_q       <= '0;
      cnt        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE) begin
        if (load_valid) begin
          data_q <= ch_data;
          en_q   <= ch_en;
          if (ch_en == 4'b0000) frame_done <= 1'b1;
          else begin
            state     <= SHIFT;
            sel       <= first_ch;
            i         <= first_word[WIDTH-1];
            bit_valid <= 1'b1;
            cnt       <= CW'(WIDTH - 1);
          end
        end
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
        i   <= cur_word[cnt - 1'b1];
      end
`ifdef TDM_PARITY_EN
      else if (!parity_flag) i <= ^cur_word;
`endif
      else if (|nxt_mask) begin
        sel <= nxt_ch;
        cnt <= CW'(WIDTH - 1);
        i   <= nxt_word[WIDTH-1];
      end else begin
        state      <= IDLE;
        frame_done <= 1'b1;
        bit_valid  <= 1'b0;
        i          <= 1'b0;
      end
    end
  end
`ifdef TDM_PARITY_EN
  // parity cycle follows bit 0 of every word
  always_ff @(posedge clk) parity_flag <= !rst && state == SHIFT && cnt == '0 && !parity_flag;
`else
  assign parity_flag = 1'b0;
`endif
endmodule

// File: tb/tb_tdm_serializer_1_4.sv
// tb_tdm_serializer_1_4: table-driven and random frames checked against a per-bit expected queue.
module tb_tdm_serializer_1_4;
  localparam int W = 8;
`ifdef TDM_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + PAR;
  logic clk = 1'b0, rst = 1'b1, load_valid = 1'b0;
  logic load_ready, i, bit_valid, parity_flag, frame_done;
  logic [4*W-1:0] ch_data = '0;
  logic [3:0] ch_en = '0;
  logic [1:0] sel;
  int vectors = 0, miscompares = 0;
  typedef struct {logic [1:0] s; logic b; logic p;} beat_t;
  typedef struct {logic [3:0] en; logic [4*W-1:0] d; int len;} vec_t;
  beat_t exp_q[$];
  vec_t tbl[7];
  always #5 clk = ~clk;
  tdm_serializer_1_4 #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .ch_data(ch_data), .ch_en(ch_en), .sel(sel), .i(i), .bit_valid(bit_valid),
    .parity_flag(parity_flag), .frame_done(frame_done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask
  task automatic check_reset(input string nm);
    chk({nm, "_sel"}, sel, 0);
    chk({nm, "_i"}, i, 0);
    chk({nm, "_bit_valid"}, bit_valid, 0);
    chk({nm, "_parity"}, parity_flag, 0);
    chk({nm, "_frame_done"}, frame_done, 0);
    chk({nm, "_load_ready"}, load_ready, 1);
  endtask
  task automatic build(input logic [3:0] en, input logic [4*W-1:0] d);
    exp_q.delete();
    for (int c = 0; c < 4; c++) if (en[c]) begin
      logic [W-1:0] w;
      w = d[c*W +: W];
      for (int b = W - 1; b >= 0; b--) exp_q.push_back('{2'(c), w[b], 1'b0});
      if (PAR != 0) exp_q.push_back('{2'(c), ^w, 1'b1});
    end
  endtask
  task automatic do_frame(input logic [3:0] en, input logic [4*W-1:0] d, input int len, input int abort_at);
    int nv;
    nv = 0;
    build(en, d);
    chk("ready_before", load_ready, 1);
    load_valid = 1'b1;
    ch_en = en;
    ch_data = d;
    @(posedge clk); #1;
    load_valid = 1'b0;
    foreach (exp_q[k]) begin
      load_valid = 1'($urandom);
      ch_en = 4'($urandom);
      ch_data = $urandom;
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        load_valid = 1'b0;
        check_reset("abort");
        @(posedge clk); #1;
        chk("abort_no_done", frame_done, 0);
        chk("abort_idle", bit_valid, 0);
        return;
      end
      chk("bit_valid", bit_valid, 1);
      chk("sel", sel, exp_q[k].s);
      chk("i", i, exp_q[k].b);
      chk("parity_flag", parity_flag, exp_q[k].p);
      chk("busy_not_ready", load_ready, 0);
      chk("done_low", frame_done, 0);
      nv += int'(bit_valid);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    chk("bit_count", nv, len);
    chk("frame_done", frame_done, 1);
    chk("end_bit_valid", bit_valid, 0);
    chk("end_i", i, 0);
    chk("end_ready", load_ready, 1);
    if (exp_q.size() > 0) chk("sel_hold", sel, exp_q[$].s);
  endtask
  initial begin
    tbl[0] = '{4'b0100, 32'h00A5_0000, FL};
    tbl[1] = '{4'b1011, 32'hFF00_8001, 3*FL};
    tbl[2] = '{4'b0000, 32'hDEAD_BEEF, 0};
    tbl[3] = '{4'b0001, 32'h0000_003C, FL};
    tbl[4] = '{4'b0011, 32'h0000_0307, 2*FL};
    tbl[5] = '{4'b1111, 32'h1234_5678, 4*FL};
    tbl[6] = '{4'b1000, 32'hC300_0000, FL};
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_reset("idle");
    end
    foreach (tbl[t]) do_frame(tbl[t].en, tbl[t].d, tbl[t].len, -1);
    do_frame(4'b0000, 32'h0, 0, -1);
    do_frame(4'b0000, 32'h0, 0, -1);
    do_frame(4'b1111, $urandom, 4*FL, FL + 4);
    do_frame(4'b0110, 32'h00F0_0F00, 2*FL, -1);
    for (int r = 0; r < 30; r++) begin
      logic [3:0] en;
      en = 4'($urandom);
      do_frame(en, $urandom, $countones(en) * FL, -1);
    end
    @(posedge clk); #1;
    chk("done_single_pulse", frame_done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
